// File: rtl/alu_op_ctrl.sv
// ALU operation controller: debounced button front end, opcode/operand latch
// and a small IDLE/CONV/SHOW sequencer driving an external BCD converter.
module alu_op_ctrl #(
    parameter int DB_CYCLES    = 1000000,
    parameter int CONV_TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] btns,
    input  logic       btnc,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [2:0] op,
    output logic [7:0] a_q,
    output logic [7:0] b_q,
    output logic       conv_start,
    input  logic       conv_done,
    output logic       show_bcd,
    output logic       err,
    output logic [1:0] state
);

    localparam int            NB       = 5;
    localparam int            CW       = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYCLES - 1);
    localparam logic [15:0]   TMO_LAST = 16'(CONV_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_SHOW = 2'd2
    } state_t;

    logic [NB-1:0] r_sync1;
    logic [NB-1:0] r_sync2;
    logic [NB-1:0] r_db;
    logic [NB-1:0] r_db_d;
    logic [CW-1:0] r_db_cnt [NB];

    logic [NB-1:0] w_press;
    logic          w_any;
    logic [1:0]    w_idx;
    logic          w_accept;
    logic          w_tmo;
    state_t        w_state_nx;

    state_t        r_state;
    logic [15:0]   r_tmo_cnt;
    logic          r_conv_start;
    logic          r_show_bcd;
    logic [2:0]    r_op;
    logic [7:0]    r_a_q;
    logic [7:0]    r_b_q;
    logic          r_err;
    logic          r_sel_vld;

    // Two-flop synchronizer; bit 4 carries btnc, bits 3:0 carry btns.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {btnc, btns};
            r_sync2 <= r_sync1;
        end
    end

    // Per-button debounce: the level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_db   <= '0;
            r_db_d <= '0;
            for (int i = 0; i < NB; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_db_d <= r_db;
            for (int i = 0; i < NB; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign w_press = r_db & ~r_db_d;

    // Lowest-index btns press event wins; the rest are dropped.
    always_comb begin
        w_any = 1'b0;
        w_idx = 2'd0;
        casez (w_press[3:0])
            4'b???1: begin w_any = 1'b1; w_idx = 2'd0; end
            4'b??10: begin w_any = 1'b1; w_idx = 2'd1; end
            4'b?100: begin w_any = 1'b1; w_idx = 2'd2; end
            4'b1000: begin w_any = 1'b1; w_idx = 2'd3; end
            default: begin w_any = 1'b0; w_idx = 2'd0; end
        endcase
    end

    // Sequencer next state; conv_done is tested before the timeout so it wins a tie.
    always_comb begin
        w_state_nx = r_state;
        w_accept   = 1'b0;
        w_tmo      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_accept = w_any;
                if (w_press[4]) begin
                    w_state_nx = ST_CONV;
                end else begin
                    w_state_nx = ST_IDLE;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    w_state_nx = ST_SHOW;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_state_nx = ST_IDLE;
                    w_tmo      = 1'b1;
                end else begin
                    w_state_nx = ST_CONV;
                end
            end
            ST_SHOW: begin
                w_accept = w_any;
                if (w_any || !r_db[4]) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_state_nx = ST_SHOW;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    // State register, conversion timer and registered sequencer outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_tmo_cnt    <= 16'd0;
            r_conv_start <= 1'b0;
            r_show_bcd   <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_conv_start <= (r_state == ST_IDLE) && (w_state_nx == ST_CONV);
            r_show_bcd   <= (w_state_nx == ST_SHOW);
            if (r_state == ST_CONV) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end else begin
                r_tmo_cnt <= 16'd0;
            end
        end
    end

    // Opcode/operand latch; re-selecting the same index flips op[2].
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op      <= 3'd0;
            r_a_q     <= 8'd0;
            r_b_q     <= 8'd0;
            r_err     <= 1'b0;
            r_sel_vld <= 1'b0;
        end else begin
            if (w_accept) begin
                if (r_sel_vld && (w_idx == r_op[1:0])) begin
                    r_op <= {~r_op[2], r_op[1:0]};
                end else begin
                    r_op <= {1'b0, w_idx};
                end
                r_sel_vld <= 1'b1;
                r_a_q     <= a;
                r_b_q     <= b;
                r_err     <= 1'b0;
            end else if (w_tmo) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign op         = r_op;
    assign a_q        = r_a_q;
    assign b_q        = r_b_q;
    assign conv_start = r_conv_start;
    assign show_bcd   = r_show_bcd;
    assign err        = r_err;
    assign state      = r_state;

endmodule

// File: tb/tb_alu_op_ctrl.sv
// Directed bench for alu_op_ctrl with short debounce and timeout windows.
module tb_alu_op_ctrl;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic [3:0] btns      = 4'd0;
    logic       btnc      = 1'b0;
    logic [7:0] a         = 8'd0;
    logic [7:0] b         = 8'd0;
    logic       conv_done = 1'b0;
    logic [2:0] op;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic       conv_start;
    logic       show_bcd;
    logic       err;
    logic [1:0] state;

    int n_cmp   = 0;
    int n_err   = 0;
    int n_start = 0;
    int snap;

    alu_op_ctrl #(
        .DB_CYCLES   (4),
        .CONV_TIMEOUT(8)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btns      (btns),
        .btnc      (btnc),
        .a         (a),
        .b         (b),
        .op        (op),
        .a_q       (a_q),
        .b_q       (b_q),
        .conv_start(conv_start),
        .conv_done (conv_done),
        .show_bcd  (show_bcd),
        .err       (err),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Counts conv_start high cycles.
    always @(negedge clk) begin
        if (conv_start === 1'b1) n_start++;
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        // Reset state
        tick(2);
        check_val("rst_state", state, 0);
        check_val("rst_op", op, 0);
        check_val("rst_aq", a_q, 0);
        check_val("rst_err", err, 0);
        check_val("rst_show", show_bcd, 0);
        check_val("rst_start", conv_start, 0);
        reset_n = 1'b1;

        // Clean btns[2] press: op=2 exactly 7 cycles after the input rises
        a = 8'h12; b = 8'h34; btns = 4'b0100;
        tick(6);
        check_val("op_before_7", op, 0);
        tick(1);
        check_val("op_sel2", op, 3'd2);
        check_val("aq_sel2", a_q, 8'h12);
        check_val("bq_sel2", b_q, 8'h34);
        a = 8'h56; btns = 4'b0000;
        tick(8);
        check_val("aq_hold", a_q, 8'h12);
        btns = 4'b0100;
        tick(7);
        check_val("op_toggle", op, 3'd6);
        check_val("aq_second", a_q, 8'h56);
        btns = 4'b0000;
        tick(8);

        // Bouncing btns[0] never qualifies
        for (int i = 0; i < 10; i++) begin
            btns[0] = ~btns[0];
            tick(2);
        end
        btns = 4'b0000;
        tick(10);
        check_val("bounce_op", op, 3'd6);
        check_val("bounce_aq", a_q, 8'h56);

        // Conversion with conv_done 3 cycles after conv_start
        snap = n_start;
        btnc = 1'b1;
        tick(7);
        check_val("conv_state", state, 1);
        check_val("conv_start_hi", conv_start, 1);
        tick(1);
        check_val("conv_start_lo", conv_start, 0);
        tick(2);
        conv_done = 1'b1;
        tick(1);
        conv_done = 1'b0;
        check_val("show_state", state, 2);
        check_val("show_bcd_hi", show_bcd, 1);
        tick(3);
        check_val("show_hold", state, 2);
        btnc = 1'b0;
        tick(6);
        check_val("show_before_rel", state, 2);
        tick(1);
        check_val("rel_state", state, 0);
        check_val("rel_show", show_bcd, 0);
        check_val("one_pulse", n_start - snap, 1);

        // Timeout with conv_done held low
        btnc = 1'b1;
        tick(7);
        check_val("tmo_conv", state, 1);
        tick(7);
        check_val("tmo_last_cyc", state, 1);
        tick(1);
        check_val("tmo_state", state, 0);
        check_val("tmo_err", err, 1);
        btnc = 1'b0;
        tick(8);
        check_val("err_sticky", err, 1);
        btns = 4'b0010;
        tick(7);
        check_val("err_clr", err, 0);
        check_val("op_sel1", op, 3'd1);
        btns = 4'b0000;
        tick(8);

        // Priority resolution and btns ignored in CONV
        btns = 4'b1000;
        tick(7);
        check_val("op_sel3", op, 3'd3);
        btns = 4'b0000;
        tick(8);
        btns = 4'b1010;
        tick(7);
        check_val("op_prio", op, 3'd1);
        btns = 4'b0000;
        tick(8);
        btnc = 1'b1;
        tick(7);
        check_val("conv2_state", state, 1);
        btns = 4'b0100;
        tick(8);
        check_val("conv_ign_op", op, 3'd1);
        check_val("conv2_tmo", state, 0);
        btns = 4'b0000; btnc = 1'b0;
        tick(8);
        check_val("idle_op_hold", op, 3'd1);

        // Reset in SHOW
        btnc = 1'b1;
        tick(7);
        conv_done = 1'b1;
        tick(1);
        check_val("show2_state", state, 2);
        snap = n_start;
        reset_n = 1'b0; btnc = 1'b0; conv_done = 1'b0;
        #1;
        check_val("arst_state", state, 0);
        check_val("arst_op", op, 0);
        check_val("arst_aq", a_q, 0);
        check_val("arst_bq", b_q, 0);
        check_val("arst_show", show_bcd, 0);
        check_val("arst_err", err, 0);
        check_val("arst_start", conv_start, 0);
        tick(2);
        reset_n = 1'b1;
        tick(12);
        check_val("no_restart", n_start - snap, 0);
        check_val("post_rst_state", state, 0);

        // Button held through reset release
        reset_n = 1'b0; btns = 4'b0100;
        tick(3);
        reset_n = 1'b1;
        tick(6);
        check_val("held_before", op, 0);
        tick(1);
        check_val("held_press", op, 3'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_ctrl.md
ALU_OP_CTRL -- requirements
Module: alu_op_ctrl

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 1000000, meaning the number of consecutive stable clock cycles before a raw button level is accepted (10 ms at 100 MHz).
REQ-002 SHALL have parameter CONV_TIMEOUT, default 64, meaning the maximum number of cycles to wait for conv_done before aborting.
REQ-003 SHALL have port clk, input, 1 bit: system clock at 100 MHz; the block SHALL use a single clock.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port btns, input, 4 bits: raw, asynchronous operation-select buttons.
REQ-006 SHALL have port btnc, input, 1 bit: raw, asynchronous convert/display request button.
REQ-007 SHALL have ports a and b, input, 8 bits each: live operand switches.
REQ-008 SHALL have port op, output, 3 bits: registered ALU opcode.
REQ-009 SHALL have ports a_q and b_q, output, 8 bits each: operands latched at the last accepted op event.
REQ-010 SHALL have port conv_start, output, 1 bit: one-cycle pulse that starts the BCD converter.
REQ-011 SHALL have port conv_done, input, 1 bit: converter completion, sampled high for at least 1 cycle.
REQ-012 SHALL have port show_bcd, output, 1 bit: display mux select (1 = converted BCD, 0 = raw digits).
REQ-013 SHALL have port err, output, 1 bit: sticky conversion-timeout flag.
REQ-014 SHALL have port state, output, 2 bits: FSM state code (IDLE=0, CONV=1, SHOW=2).

Function
REQ-015 SHALL pass each of btns[3:0] and btnc through a 2-flop synchronizer, followed by its own debounce counter.
REQ-016 SHALL change a debounced level only after the synchronized level has differed from it for DB_CYCLES consecutive cycles; any bounce SHALL reset that button's counter.
REQ-017 SHALL generate a one-cycle press event for each 0->1 transition of a debounced level.
REQ-018 SHALL resolve simultaneous btns press events by priority: the lowest index wins and the other events are discarded.
REQ-019 On a btns[i] press event, if i differs from the last selected index, op SHALL become {1'b0, i[1:0]}.
REQ-020 On a btns[i] press event, if i equals the last selected index, op[2] SHALL toggle and op[1:0] SHALL hold.
REQ-021 SHALL update op, a_q, b_q and clear err on the cycle after an accepted press event; a_q and b_q SHALL capture a and b as sampled on the event cycle.
REQ-022 IDLE: a btnc press event SHALL move the FSM to CONV, with conv_start high for exactly the first cycle in CONV.
REQ-023 IDLE: a btns press event SHALL be accepted with no state change.
REQ-024 CONV: btns press events SHALL be ignored, with op, a_q and b_q held.
REQ-025 CONV: conv_done high SHALL move the FSM to SHOW on the next cycle.
REQ-026 CONV: a 16-bit cycle counter SHALL reach CONV_TIMEOUT without conv_done before the FSM moves to IDLE and sets err=1.
REQ-027 CONV: if conv_done and the timeout occur on the same cycle, conv_done SHALL win.
REQ-028 SHOW: show_bcd SHALL be 1; show_bcd SHALL be 0 in all other states.
REQ-029 SHOW: a debounced btnc level of 0 SHALL move the FSM to IDLE.
REQ-030 SHOW: a btns press event SHALL be accepted and SHALL move the FSM to IDLE; this SHALL take precedence over the btnc release.
REQ-031 A btnc press event while in CONV or SHOW SHALL be ignored; conv_start SHALL never re-pulse without passing through IDLE.
REQ-032 Once set, err SHALL be cleared only by an accepted btns press event or by reset.

Reset
REQ-033 On reset_n=0 the block SHALL immediately force state=IDLE, op=0, a_q=0, b_q=0, conv_start=0, show_bcd=0 and err=0, and SHALL clear all debounce counters and debounced levels to 0.
REQ-034 Asserting reset_n mid-CONV or mid-SHOW SHALL abort the operation with no conv_start pulse after release.
REQ-035 After reset_n release, a button already held high SHALL produce a press event DB_CYCLES+2 cycles later.

Verification (bench with DB_CYCLES=4, CONV_TIMEOUT=8)
REQ-036 Hold btns=4'b0100 clean with a=8'h12, b=8'h34 -> op=3'd2, a_q=8'h12, b_q=8'h34 exactly 7 cycles after the input rises; a second press -> op=3'd6.
REQ-037 Toggle btns[0] every 2 cycles for 20 cycles, then release -> op unchanged and no press event.
REQ-038 Press btnc in IDLE, assert conv_done 3 cycles after conv_start -> conv_start is a single-cycle pulse, state=SHOW, show_bcd=1; release btnc -> IDLE and show_bcd=0 after debounce.
REQ-039 Press btnc with conv_done held low -> after 8 cycles in CONV, state=IDLE and err=1; a subsequent btns[1] press -> err=0, op=3'd1.
REQ-040 Press btns=4'b1010 simultaneously -> op=3'd1; a btns press during CONV -> op unchanged.
REQ-041 Drive reset_n low during SHOW -> all outputs zero within the same cycle, state=IDLE, with no conv_start pulse after release.
